// File: rtl/seq_mult_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package seq_mult_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int PROD_W    = 2 * WIDTH_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_shift_add_mult_adder.sv
// Ripple-carry adder used as the multiplier's datapath adder (64 bits by default, N = 2*WIDTH generally).
module rca_adder #(
   parameter int N = 64
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   // Carry is a single procedural variable, so the chain does not form a combinational loop on one vector.
   always_comb begin
      logic carry;
      carry = cin;
      sum   = '0;
      for (int i = 0; i < N; i++) begin
         sum[i] = x[i] ^ y[i] ^ carry;
         carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one addition per RUN cycle through rca_adder.
// Optional early termination when the remaining multiplier is zero: define SEQ_MULT_EARLY_TERM_EN.
module seq_shift_add_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t            state_q, state_d;
   logic [PW-1:0]     product_q, product_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [PW-1:0]     addY;
   logic [PW-1:0]     addSum;
   logic              cout_unused;
   logic              earlyStop;

   assign addY = mplier_q[0] ? mcand_q : '0;

   rca_adder #(.N(PW)) u_adder (
      .x    (product_q),
      .y    (addY),
      .cin  (1'b0),
      .sum  (addSum),
      .cout (cout_unused)
   );

`ifdef SEQ_MULT_EARLY_TERM_EN
   assign earlyStop = (mplier_q == '0);
`else
   assign earlyStop = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         product_q <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         product_q <= product_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
      end
   end

   // DONE ignores in_valid, so a new operand can only be taken one cycle after out_ready.
   always_comb begin
      state_d   = state_q;
      product_d = product_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mcand_d   = {{WIDTH{1'b0}}, a};
               mplier_d  = b;
               product_d = '0;
               count_d   = '0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (earlyStop) begin
               state_d = ST_DONE;
            end else begin
               product_d = addSum;
               mcand_d   = mcand_q << 1;
               mplier_d  = mplier_q >> 1;
               count_d   = count_q + CNT_W'(1);
               if (count_q == LAST_CNT) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN);
   assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult; expected latency follows SEQ_MULT_EARLY_TERM_EN when defined.
module tb_seq_shift_add_mult;
   import seq_mult_pkg::*;

   localparam int W = WIDTH_DEF;

   typedef struct {
      logic [PROD_W-1:0] prod;
      int                lat;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      a;
   logic [W-1:0]      b;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] product;
   logic              busy;

   exp_t expQ[$];
   int   checks;
   int   failures;
   int   cycleCount;
   int   acceptCycle;

   seq_shift_add_mult #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [PROD_W-1:0] obs, input logic [PROD_W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int expLatency(input logic [W-1:0] bv);
      int msb;
`ifdef SEQ_MULT_EARLY_TERM_EN
      if (bv == '0) return 1;
      msb = 0;
      for (int i = 0; i < W; i++) if (bv[i]) msb = i;
      return (msb + 2 < W) ? msb + 2 : W;
`else
      msb = int'(bv[0]);
      return W + msb - msb;
`endif
   endfunction

   // Waits for in_ready, offers one operand pair, and records the accepting edge.
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      acceptCycle = cycleCount;
      e.prod = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
      e.lat  = expLatency(bv);
      expQ.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("in_ready_drop", {63'd0, in_ready}, 64'd0);
   endtask

   // Waits for out_valid, scores product and latency, holds DONE for holdCycles, then consumes.
   task automatic waitForResult(input int holdCycles, input bit consume);
      exp_t e;
      int guard;
      guard = 0;
      while (!out_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!out_valid) begin
         checkOutput("out_valid_timeout", {63'd0, out_valid}, 64'd1);
      end else if (expQ.size() == 0) begin
         checkOutput("unexpected_output", {63'd0, out_valid}, 64'd0);
      end else begin
         e = expQ.pop_front();
         checkOutput("product", product, e.prod);
         checkOutput("latency", 64'(cycleCount - acceptCycle), 64'(e.lat));
         for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("hold_product", product, e.prod);
         end
      end
      if (consume) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         checkOutput("out_valid_drop", {63'd0, out_valid}, 64'd0);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      cycleCount = 0;
      acceptCycle = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_product", product, 64'd0);
      checkOutput("reset_flags", {60'd0, in_ready, out_valid, busy, 1'b0}, {60'd0, 4'b1000});
      rst_n = 1'b1;

      applyStimulus(32'd3, 32'd5);
      checkOutput("busy_run", {63'd0, busy}, 64'd1);
      waitForResult(0, 1'b1);

      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitForResult(0, 1'b1);
      checkOutput("max_product", product, 64'hFFFF_FFFE_0000_0001);

      // DONE held for 10 cycles, then out_ready with a simultaneous in_valid that must not be taken.
      applyStimulus(32'd11, 32'd13);
      waitForResult(10, 1'b0);
      a = 32'd7;
      b = 32'd6;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("done_ignores_in_valid", {62'd0, in_ready, busy}, {62'd0, 2'b10});
      @(posedge clk);
      #1;
      acceptCycle = cycleCount;
      expQ.push_back('{prod: 64'd42, lat: expLatency(32'd6)});
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("accept_after_done", {63'd0, busy}, 64'd1);
      waitForResult(0, 1'b1);

      // Asynchronous reset in the middle of a RUN sequence.
      applyStimulus(32'd1000, 32'd1000);
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_product", product, 64'd0);
      checkOutput("async_rst_flags", {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'd2, 32'd9);
      waitForResult(0, 1'b1);

      applyStimulus(32'd123, 32'd0);
      waitForResult(0, 1'b1);
      applyStimulus(32'd77, 32'd1);
      waitForResult(0, 1'b1);
      applyStimulus(32'd5, 32'h8000_0000);
      waitForResult(0, 1'b1);
      checkOutput("idle_keeps_product", product, 64'h0000_0002_8000_0000);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(W'($urandom), W'($urandom_range(0, 65535)));
         waitForResult(1, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
